fifo_wr_arbiter: RTL and testbench

Round-robin write arbiter that shares one synchronous FIFO write port (wr_en/data_in, gated by full) among NUM_REQ producers using valid/ready handshakes. A winning requester holds a burst lock for up to BURST_LEN beats, so consecutive words from one producer stay contiguous in the FIFO. The block sits directly in front of the FIFO. Its FIFO-facing outputs are combinational so that writes are never issued into a full FIFO.

---
 rtl/fifo_arb_pkg.sv | 25 ++
 rtl/rr_priority_pick.sv | 22 ++
 rtl/fifo_wr_arbiter.sv | 95 +++++++++
 tb/tb_fifo_wr_arbiter.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types, constants and the round-robin pick helper
// for the FIFO write arbiter.
package fifo_arb_pkg;
    localparam int DEF_DATA_WIDTH = 8;

    typedef enum logic {IDLE, LOCK} arb_state_t;

    typedef struct packed {
        logic       found;
        logic [4:0] idx;
    } pick_t;

    // Lowest set bit of an already-rotated vector, offset back by ptr; caller reduces mod N.
    function automatic pick_t rr_pick(input logic [15:0] eligible, input logic [3:0] ptr);
        pick_t p;
        p = '0;
        for (int i = 15; i >= 0; i--) begin
            if (eligible[i]) begin
                p.found = 1'b1;
                p.idx   = 5'(i) + 5'(ptr);
            end
        end
        return p;
    endfunction
endpackage

// File: rtl/rr_priority_pick.sv
// rr_priority_pick: combinational round-robin search -- rotate by ptr,
// priority encode, unrotate back to a requester index.
module rr_priority_pick
    import fifo_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]         i_eligible,
    input  logic [$clog2(N)-1:0] i_ptr,
    output logic                 o_found,
    output logic [$clog2(N)-1:0] o_idx
);
    localparam int IW = $clog2(N);

    logic [15:0] w_rot;
    pick_t       w_pick;

    assign w_rot   = 16'(N'({i_eligible, i_eligible} >> i_ptr));
    assign w_pick  = rr_pick(w_rot, 4'(i_ptr));
    assign o_found = w_pick.found;
    assign o_idx   = IW'((w_pick.idx >= 5'(N)) ? w_pick.idx - 5'(N) : w_pick.idx);
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one FIFO write port among
// NUM_REQ producers, with a burst lock of up to BURST_LEN beats per winner.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_REQ    = 4,
    parameter int BURST_LEN  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            i_req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
    input  logic [NUM_REQ-1:0]            i_req_mask,
    output logic [NUM_REQ-1:0]            o_req_ready,
    input  logic                          i_full,
    output logic                          o_wr_en,
    output logic [DATA_WIDTH-1:0]         o_data_in,
    output logic [$clog2(NUM_REQ)-1:0]    o_grant_id,
    output logic                          o_busy
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int BW = $clog2(BURST_LEN + 1);

    arb_state_t         r_state, w_state_nxt;
    logic [IW-1:0]      r_owner, r_rr_ptr, w_owner_nxt, w_rr_ptr_nxt, w_ptr, w_pick_idx, w_idx;
    logic [BW-1:0]      r_beat_cnt, w_beat_nxt;
    logic [NUM_REQ-1:0] w_elig;
    logic               w_owner_elig, w_found, w_write;

    function automatic logic [IW-1:0] inc_mod(input logic [IW-1:0] v);
        return (v == IW'(NUM_REQ - 1)) ? '0 : v + 1'b1;
    endfunction

    assign w_elig       = i_req_valid & i_req_mask;
    assign w_owner_elig = (r_state == LOCK) && w_elig[r_owner];
    // A released lock searches from owner+1 in the same cycle, so there is no bubble.
    assign w_ptr        = (r_state == LOCK) ? inc_mod(r_owner) : r_rr_ptr;

    rr_priority_pick #(.N(NUM_REQ)) u_pick (
        .i_eligible (w_elig),
        .i_ptr      (w_ptr),
        .o_found    (w_found),
        .o_idx      (w_pick_idx)
    );

    assign w_idx       = w_owner_elig ? r_owner : w_pick_idx;
    assign w_write     = !rst && !i_full && (w_owner_elig || w_found);
    assign o_wr_en     = w_write;
    assign o_req_ready = w_write ? NUM_REQ'(1) << w_idx : '0;
    assign o_data_in   = w_write ? i_req_data[w_idx*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign o_grant_id  = w_write ? w_idx : '0;
    assign o_busy      = !rst && (r_state == LOCK);

    always_comb begin
        w_state_nxt  = r_state;
        w_owner_nxt  = r_owner;
        w_rr_ptr_nxt = r_rr_ptr;
        w_beat_nxt   = r_beat_cnt;
        if (w_owner_elig) begin
            if (!i_full) begin
                w_beat_nxt = r_beat_cnt + 1'b1;
                if (w_beat_nxt == BW'(BURST_LEN)) begin
                    w_state_nxt  = IDLE;
                    w_rr_ptr_nxt = inc_mod(r_owner);
                end
            end
        end else if (w_write) begin
            if (BURST_LEN == 1) begin
                w_rr_ptr_nxt = inc_mod(w_idx);
            end else begin
                w_state_nxt = LOCK;
                w_owner_nxt = w_idx;
                w_beat_nxt  = BW'(1);
            end
        end else if (r_state == LOCK) begin
            w_state_nxt  = IDLE;
            w_rr_ptr_nxt = inc_mod(r_owner);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_owner    <= '0;
            r_rr_ptr   <= '0;
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_owner    <= w_owner_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_beat_cnt <= w_beat_nxt;
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed scenarios plus random traffic on a BURST_LEN=4
// and a BURST_LEN=1 arbiter, checked against a rule-level reference model.
module tb_fifo_wr_arbiter;
    localparam int N  = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          full = 1'b0;
    logic [N-1:0]  valid = '0;
    logic [N-1:0]  mask = '1;
    logic [N*DW-1:0] data = '0;

    logic [N-1:0]  rdy0, rdy1;
    logic          we0, we1, busy0, busy1;
    logic [DW-1:0] din0, din1;
    logic [1:0]    gid0, gid1;

    int checks = 0, errors = 0;
    int m_owner [2];
    int m_beats [2];
    int m_ptr [2];
    int burst [2];
    int waits [N];
    int q0 [$];
    int q1 [$];
    int l_gid0, l_busy0;

    fifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(N), .BURST_LEN(4)) u_dut0 (
        .clk(clk), .rst(rst), .i_req_valid(valid), .i_req_data(data), .i_req_mask(mask),
        .o_req_ready(rdy0), .i_full(full), .o_wr_en(we0), .o_data_in(din0),
        .o_grant_id(gid0), .o_busy(busy0)
    );

    fifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(N), .BURST_LEN(1)) u_dut1 (
        .clk(clk), .rst(rst), .i_req_valid(valid), .i_req_data(data), .i_req_mask(mask),
        .o_req_ready(rdy1), .i_full(full), .o_wr_en(we1), .o_data_in(din1),
        .o_grant_id(gid1), .o_busy(busy1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        logic [N-1:0]  elig;
        logic          ew [2];
        int            eid [2];
        int            s;
        logic          a_we [2];
        logic [N-1:0]  a_rdy [2];
        logic [DW-1:0] a_din [2];
        int            a_gid [2];
        logic          a_busy [2];
        @(negedge clk);
        a_we[0] = we0;     a_we[1] = we1;
        a_rdy[0] = rdy0;   a_rdy[1] = rdy1;
        a_din[0] = din0;   a_din[1] = din1;
        a_gid[0] = gid0;   a_gid[1] = gid1;
        a_busy[0] = busy0; a_busy[1] = busy1;
        elig = valid & mask;
        for (int k = 0; k < 2; k++) begin
            ew[k] = 1'b0;
            eid[k] = 0;
            if (!rst && !full) begin
                if (m_owner[k] >= 0 && elig[m_owner[k]]) begin
                    ew[k] = 1'b1;
                    eid[k] = m_owner[k];
                end else begin
                    s = (m_owner[k] >= 0) ? (m_owner[k] + 1) % N : m_ptr[k];
                    for (int j = 0; j < N; j++) begin
                        if (!ew[k] && elig[(s + j) % N]) begin
                            ew[k] = 1'b1;
                            eid[k] = (s + j) % N;
                        end
                    end
                end
            end
            chk($sformatf("we%0d", k), a_we[k], ew[k]);
            chk($sformatf("ready%0d", k), a_rdy[k], ew[k] ? (1 << eid[k]) : 0);
            chk($sformatf("data%0d", k), a_din[k], ew[k] ? data[eid[k]*DW +: DW] : 0);
            if (ew[k]) chk($sformatf("gid%0d", k), a_gid[k], eid[k]);
            chk($sformatf("busy%0d", k), a_busy[k], !rst && m_owner[k] >= 0);
        end
        if (a_we[0]) q0.push_back(a_gid[0]);
        if (a_we[1]) q1.push_back(a_gid[1]);
        l_gid0 = a_gid[0];
        l_busy0 = a_busy[0];
        for (int i = 0; i < N; i++) begin
            if (rst || !elig[i] || (a_we[0] && a_gid[0] == i)) waits[i] = 0;
            else if (a_we[0]) waits[i]++;
            chk($sformatf("fair%0d", i), waits[i] <= (N - 1) * 4, 1);
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_owner[k] = -1; m_beats[k] = 0; m_ptr[k] = 0;
            end else if (m_owner[k] >= 0 && elig[m_owner[k]]) begin
                if (!full) begin
                    m_beats[k]++;
                    if (m_beats[k] == burst[k]) begin
                        m_ptr[k] = (m_owner[k] + 1) % N;
                        m_owner[k] = -1;
                    end
                end
            end else if (ew[k]) begin
                if (burst[k] == 1) m_ptr[k] = (eid[k] + 1) % N;
                else begin
                    m_owner[k] = eid[k];
                    m_beats[k] = 1;
                end
            end else if (m_owner[k] >= 0) begin
                m_ptr[k] = (m_owner[k] + 1) % N;
                m_owner[k] = -1;
            end
        end
        #1;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            data = {$urandom};
            cycle();
        end
    endtask

    initial begin
        burst[0] = 4; burst[1] = 1;
        for (int k = 0; k < 2; k++) begin
            m_owner[k] = -1; m_beats[k] = 0; m_ptr[k] = 0;
        end
        for (int i = 0; i < N; i++) waits[i] = 0;
        rst = 1'b1; valid = '1; mask = '1; full = 1'b0;
        step(2);
        rst = 1'b0;
        q0.delete();
        step(16);
        chk("rot_len", q0.size(), 16);
        for (int i = 0; i < 16; i++) chk($sformatf("rot%0d", i), q0[i], i / 4);

        valid = 4'b0100;
        step(2);
        valid = '1; full = 1'b1;
        step(3);
        full = 1'b0;
        q0.delete();
        step(4);
        chk("stall_len", q0.size(), 4);
        chk("stall0", q0[0], 2);
        chk("stall1", q0[1], 2);
        chk("stall2", q0[2], 3);
        chk("stall3", q0[3], 3);

        rst = 1'b1; step(1); rst = 1'b0;
        valid = 4'b0010;
        step(1);
        valid = 4'b1000;
        step(1);
        chk("early_gid", l_gid0, 3);
        chk("early_busy0", l_busy0, 1);
        step(1);
        chk("early_busy1", l_busy0, 1);

        rst = 1'b1; step(1); rst = 1'b0;
        mask = 4'b1010; valid = '1;
        q0.delete();
        step(16);
        chk("mask_len", q0.size(), 16);
        for (int i = 0; i < 16; i++) chk($sformatf("mask%0d", i), q0[i], ((i / 4) % 2 == 1) ? 3 : 1);
        step(2);
        mask = 4'b1000;
        step(1);
        chk("mask_rel", l_gid0, 3);

        rst = 1'b1; step(1); rst = 1'b0;
        mask = '1;
        q1.delete();
        valid = 4'b1000;
        step(1);
        valid = 4'b1001;
        step(3);
        chk("wrap_len", q1.size(), 4);
        for (int i = 0; i < 4; i++) chk($sformatf("wrap%0d", i), q1[i], (i % 2 == 0) ? 3 : 0);

        repeat (3000) begin
            rst   = ($urandom_range(0, 99) == 0);
            valid = N'($urandom);
            mask  = ($urandom_range(0, 3) == 0) ? N'($urandom) : '1;
            full  = ($urandom_range(0, 3) == 0);
            step(1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
